// File: rtl/seq_magnitude_comparator_if.sv
// seq_magnitude_comparator_if: compare request (start, signed_mode, a, b) and completion (busy, done, result) bundle
interface seq_magnitude_comparator_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             signed_mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [1:0]       result;
  modport master (output start, signed_mode, a, b, input busy, done, result);
  modport slave  (input start, signed_mode, a, b, output busy, done, result);
endinterface

// File: rtl/seq_magnitude_comparator.sv
// seq_magnitude_comparator: MSB-first DIGIT-per-cycle early-exit magnitude compare; clk, rst_n (sync low), bus.slave (start/signed_mode/a/b in, busy/done/result out: 00 eq, 01 a>b, 10 a<b)
module seq_magnitude_comparator #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input logic                   clk,
  input logic                   rst_n,
  seq_magnitude_comparator_if.slave bus
);
  localparam int NDIG = WIDTH / DIGIT;
  localparam int IW = NDIG > 1 ? $clog2(NDIG) : 1;
  typedef enum logic [1:0] {IDLE, COMPARE, DONE} state_t;
  state_t           state, nxt;
  logic [WIDTH-1:0] ra, rb, flip;
  logic [IW-1:0]    idx;
  logic [1:0]       res;
  logic             gt, lt, last;
  assign flip = WIDTH'(bus.signed_mode) << (WIDTH - 1);
  assign gt   = ra[WIDTH-1 -: DIGIT] > rb[WIDTH-1 -: DIGIT];
  assign lt   = ra[WIDTH-1 -: DIGIT] < rb[WIDTH-1 -: DIGIT];
  assign last = idx == IW'(NDIG - 1);
  assign bus.busy   = state == COMPARE;
  assign bus.done   = state == DONE;
  assign bus.result = res;
  always_ff @(posedge clk)
    state <= !rst_n ? IDLE : nxt;
  always_comb begin
    nxt = state;
    nxt = state == IDLE    ? (bus.start ? COMPARE : IDLE) :
          state == COMPARE ? (gt || lt || last ? DONE : COMPARE) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ra  <= '0;
      rb  <= '0;
      idx <= '0;
      res <= 2'b00;
    end else if (state == IDLE && bus.start) begin
      ra  <= bus.a ^ flip;
      rb  <= bus.b ^ flip;
      idx <= '0;
    end else if (state == COMPARE) begin
      if (gt) res <= 2'b01;
      else if (lt) res <= 2'b10;
      else if (last) res <= 2'b00;
      else begin
        ra  <= ra << DIGIT;
        rb  <= rb << DIGIT;
        idx <= idx + 1'b1;
      end
    end
  end
endmodule
